// File: rtl/div_sequencer.sv
// -----------------------------------------------------------------------------
// div_sequencer
//   Multi-cycle integer divider for the EX stage. One restoring radix-2 step
//   per cycle; a W-bit operation takes W CALC cycles. Divide-by-zero and the
//   signed overflow case skip CALC and go straight to DONE.
//
// Ports
//   s_clk_i       single clock
//   s_rst_i       synchronous, active-high reset
//   s_start_i     request a division (sampled only in IDLE)
//   s_op_i        00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start)
//   s_dividend_i  dividend (sampled with start)
//   s_divisor_i   divisor (sampled with start)
//   s_stall_i     MA stage stall, holds DONE
//   s_flush_i     abort any operation, return to IDLE
//   s_busy_o      high in CALC or DONE
//   s_finished_o  result valid (DONE only)
//   s_result_o    quotient or remainder per latched op, 0 outside DONE
// -----------------------------------------------------------------------------
module div_sequencer #(
    parameter int W = 32
) (
    input  logic         s_clk_i,
    input  logic         s_rst_i,
    input  logic         s_start_i,
    input  logic [1:0]   s_op_i,
    input  logic [W-1:0] s_dividend_i,
    input  logic [W-1:0] s_divisor_i,
    input  logic         s_stall_i,
    input  logic         s_flush_i,
    output logic         s_busy_o,
    output logic         s_finished_o,
    output logic [W-1:0] s_result_o
);

    localparam int            CW        = $clog2(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
    localparam logic [W-1:0]  INT_MIN   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_next;

    // Operation state
    logic [W-1:0]  quot_q;       // dividend shifts out, quotient bits shift in
    logic [W-1:0]  rem_q;        // partial remainder, always < divisor between steps
    logic [W-1:0]  divisor_q;    // |divisor| for signed ops
    logic [CW-1:0] cnt_q;
    logic          is_rem_q;     // 1: return remainder, 0: return quotient
    logic          quot_neg_q;   // operand signs differed on a signed op
    logic          rem_neg_q;    // dividend was negative on a signed op

    // Decode of the request presented in IDLE
    logic         op_signed;
    logic         dividend_neg;
    logic         divisor_neg;
    logic [W-1:0] dividend_abs;
    logic [W-1:0] divisor_abs;
    logic         div_zero;
    logic         overflow;
    logic         accept;

    assign op_signed    = ~s_op_i[0];
    assign dividend_neg = op_signed & s_dividend_i[W-1];
    assign divisor_neg  = op_signed & s_divisor_i[W-1];
    assign dividend_abs = dividend_neg ? -s_dividend_i : s_dividend_i;
    assign divisor_abs  = divisor_neg  ? -s_divisor_i  : s_divisor_i;
    assign div_zero     = (s_divisor_i == '0);
    assign overflow     = op_signed && (s_dividend_i == INT_MIN) && (s_divisor_i == '1);
    assign accept       = (state == IDLE) && s_start_i && !s_flush_i;

    // One restoring step: shift {rem, quot} left, trial-subtract at W+1 bits.
    // If the shifted-out MSB is 1 the trial result is always non-negative, so
    // the W-bit stored remainder never loses information.
    logic [W:0] rem_shift;
    logic [W:0] trial;

    assign rem_shift = {rem_q, quot_q[W-1]};
    assign trial     = rem_shift - {1'b0, divisor_q};

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: if (s_start_i) state_next = (div_zero || overflow) ? DONE : CALC;
            CALC: if (cnt_q == LAST_STEP) state_next = DONE;
            DONE: if (!s_stall_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Flush overrides start and stall in every state.
        if (s_flush_i) state_next = IDLE;
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge s_clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values and evaluation order is moot.
        if (s_rst_i) begin
            // NOTE: these are a handful of flops, not a memory array, so
            // clearing them in reset is cheap and keeps the result port clean.
            quot_q     <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            is_rem_q   <= 1'b0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
        end else if (accept) begin
            is_rem_q <= s_op_i[1];
            cnt_q    <= '0;
            if (div_zero) begin
                // Quotient all-ones, remainder is the raw dividend.
                quot_q     <= '1;
                rem_q      <= s_dividend_i;
                divisor_q  <= '0;
                quot_neg_q <= 1'b0;
                rem_neg_q  <= 1'b0;
            end else if (overflow) begin
                quot_q     <= INT_MIN;
                rem_q      <= '0;
                divisor_q  <= '0;
                quot_neg_q <= 1'b0;
                rem_neg_q  <= 1'b0;
            end else begin
                quot_q     <= dividend_abs;
                rem_q      <= '0;
                divisor_q  <= divisor_abs;
                quot_neg_q <= dividend_neg ^ divisor_neg;
                rem_neg_q  <= dividend_neg;
            end
        end else if (state == CALC) begin
            cnt_q <= cnt_q + CW'(1);
            if (!trial[W]) begin
                rem_q  <= trial[W-1:0];
                quot_q <= {quot_q[W-2:0], 1'b1};
            end else begin
                rem_q  <= rem_shift[W-1:0];
                quot_q <= {quot_q[W-2:0], 1'b0};
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: sign fix-up is combinational on registers frozen in DONE.
    // -------------------------------------------------------------------------
    logic [W-1:0] result_mag;
    logic         result_neg;

    assign result_mag = is_rem_q ? rem_q : quot_q;
    assign result_neg = is_rem_q ? rem_neg_q : quot_neg_q;

    always_comb begin
        s_result_o = '0;
        if (state == DONE) s_result_o = result_neg ? -result_mag : result_mag;
    end

    assign s_busy_o     = (state == CALC) || (state == DONE);
    assign s_finished_o = (state == DONE);

endmodule

// File: tb/tb_div_sequencer.sv
// -----------------------------------------------------------------------------
// tb_div_sequencer
//   Directed self-checking bench for div_sequencer (W = 32). Inputs change and
//   outputs are sampled 1 ns after each rising edge. A start asserted in the
//   cycle after edge N is sampled at edge N+1; a normal operation then shows
//   s_finished_o 33 ticks after the start was asserted, a special case 1 tick.
// -----------------------------------------------------------------------------
module tb_div_sequencer;

    localparam int W = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         stall;
    logic         flush;
    logic         busy;
    logic         finished;
    logic [W-1:0] result;

    int total  = 0;
    int passed = 0;

    div_sequencer #(.W(W)) dut (
        .s_clk_i      (clk),
        .s_rst_i      (rst),
        .s_start_i    (start),
        .s_op_i       (op),
        .s_dividend_i (dividend),
        .s_divisor_i  (divisor),
        .s_stall_i    (stall),
        .s_flush_i    (flush),
        .s_busy_o     (busy),
        .s_finished_o (finished),
        .s_result_o   (result)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] observed,
                         input logic [W-1:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    endtask

    // Pulse start for one cycle, wait (bounded) for finished, check latency
    // and result, then let DONE drain with stall low and check the return.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_result, input int exp_lat);
        int n;
        op       = o;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        n        = 1;
        while (!finished && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, W'(n), W'(exp_lat));
        check(tag, result, exp_result);
        tick();
        check({tag, "_idle"}, {30'd0, busy, finished}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        dividend = '0;
        divisor  = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        tick();
        tick();
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_finished", {31'd0, finished}, 32'd0);
        check("rst_result",   result,            32'd0);
        rst = 1'b0;
        tick();
        check("idle_result", result, 32'd0);

        // Basic unsigned
        run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2,  33);

        // Signed, truncating toward zero
        run_op("div_m7_2",  OP_DIV, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",  OP_REM, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run_op("div_7_m2",  OP_DIV, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);

        // Special cases complete in one cycle
        run_op("divu_by0", OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu_by0", OP_REMU, 32'd5,         32'd0,         32'd5,         1);
        run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

        // Flush mid-CALC, then an immediate new operation
        op       = OP_DIVU;
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("flush_pre_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_busy",     {31'd0, busy},     32'd0);
        check("flush_finished", {31'd0, finished}, 32'd0);
        run_op("divu_9_3_after_flush", OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

        // Stall in DONE, with start pulses (new operands) ignored during CALC
        stall    = 1'b1;
        op       = OP_DIVU;
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        op       = OP_REMU;
        dividend = 32'd55;
        divisor  = 32'd4;
        start    = 1'b1;
        tick();
        tick();
        start = 1'b0;
        for (int i = 0; i < 24; i++) tick();
        check("stall_pre_done", {31'd0, finished}, 32'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("stall_fin_%0d", i), {31'd0, finished}, 32'd1);
            check($sformatf("stall_res_%0d", i), result, 32'd14);
            if (i == 5) stall = 1'b0;
            else tick();
        end
        tick();
        check("stall_release", {31'd0, finished}, 32'd0);

        // Reset mid-CALC
        op       = OP_DIVU;
        dividend = 32'd77;
        divisor  = 32'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_outs", {29'd0, busy, finished, |result}, 32'd0);
        run_op("divu_100_7_after_rst", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter W, default 32, operand and result width in bits; only W=32 is supported in the EX stage.
REQ-002 SHALL have port s_clk_i, input, 1, the single clock.
REQ-003 SHALL have port s_rst_i, input, 1, reset (synchronous, active-high).
REQ-004 SHALL have port s_start_i, input, 1, request a division; sampled only in IDLE.
REQ-005 SHALL have port s_op_i, input, 2, operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
REQ-006 SHALL have port s_dividend_i, input, W, dividend; sampled with start.
REQ-007 SHALL have port s_divisor_i, input, W, divisor; sampled with start.
REQ-008 SHALL have port s_stall_i, input, 1, MA stage stall; holds DONE.
REQ-009 SHALL have port s_flush_i, input, 1, abort any operation.
REQ-010 SHALL have port s_busy_o, output, 1, high in CALC or DONE.
REQ-011 SHALL have port s_finished_o, output, 1, result valid; drives EX bubble release.
REQ-012 SHALL have port s_result_o, output, W, quotient or remainder per latched op.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE, with a registered state and no latches.
REQ-014 SHALL move IDLE->CALC on an edge with s_start_i=1, s_flush_i=0, no special case; latch |dividend|, |divisor| (signed ops), signs, op; clear remainder and counter.
REQ-015 SHALL move IDLE->DONE directly on start when the divisor is 0 or on the signed overflow case (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF).
REQ-016 SHALL perform one restoring radix-2 step per CALC cycle: shift {rem,quot} left 1, subtract divisor from the (W+1)-bit rem, set quot LSB when the result is non-negative.
REQ-017 SHALL use a $clog2(W)-bit iteration counter and move CALC->DONE after exactly W steps; s_finished_o first high 33 cycles after the start edge for W=32.
REQ-018 SHALL keep s_finished_o high in DONE only; DONE->IDLE on the first edge with s_stall_i=0; DONE is held while s_stall_i=1.
REQ-019 SHALL hold s_result_o stable for the whole of DONE and drive it to 0 outside DONE.
REQ-020 SHALL, for signed ops, negate the quotient when the operand signs differ and give the remainder the sign of the dividend (two's complement, truncating toward zero).
REQ-021 SHALL return on divide-by-zero: quotient 0xFFFFFFFF for DIV and DIVU, remainder = dividend for REM and REMU.
REQ-022 SHALL return on signed overflow: quotient 0x80000000, remainder 0.
REQ-023 SHALL ignore s_start_i while busy, with no relatching of operands.
REQ-024 SHALL, on s_flush_i=1 in any state, go to IDLE on that edge with s_finished_o=0 the next cycle; flush takes priority over start and stall.
REQ-025 SHALL compute every arithmetic result modulo 2^W, with intermediate subtraction at W+1 bits.

Reset
REQ-026 SHALL, with s_rst_i=1 at an edge, force IDLE, counter 0, datapath registers 0, s_busy_o=0, s_finished_o=0, s_result_o=0.
REQ-027 SHALL give reset priority over flush, start and stall, including reset mid-CALC; the first start after reset is accepted normally.

Verification
REQ-028 SHALL cover: DIVU 100/7 start at cycle 0 -> finished cycles 33.., result 14; repeat with REMU -> 2.
REQ-029 SHALL cover: DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-030 SHALL cover: DIVU 5/0 -> finished next cycle, 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-031 SHALL cover: flush at cycle 10 of CALC -> busy=0 cycle 11; new DIVU 9/3 started cycle 11 -> 3 at cycle 44.
REQ-032 SHALL cover: stall held 5 cycles in DONE -> finished and result stable 6 cycles; start pulses during CALC ignored.
REQ-033 SHALL cover: s_rst_i mid-CALC -> all outputs 0 next cycle; a subsequent DIVU 100/7 -> 14.
